// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and writes them to consecutive word addresses.
// Latency: imem_we pulses for one cycle, starting in the cycle after the edge that accepts the fourth byte of a word.
// Backpressure: byte_ready is low except in LOAD, and drops for the single WRITE cycle; the source holds unaccepted bytes.
//
// Ports:
//   clk, reset (async, active-low)           clock and reset
//   start, num_words                         load request; sampled only in IDLE or DONE
//   byte_valid, byte_data, byte_ready        program byte stream, most-significant byte of each word first
//   imem_we, imem_waddr, imem_wdata          instruction-memory write port
//   cpu_hold                                 stalls the PC/datapath while a load is in progress
//   load_done, load_error                    status of the last load or start request
//   words_written, checksum                  progress counter and XOR of the words written
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_written,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  localparam logic [1:0]      LAST_LANE = 2'((DATA_W / 8) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          lane;
  logic [DATA_W-9:0]   byte_buf;   // lanes already received for the word being assembled
  logic [ADDR_W:0]     num_words_q;

  logic                start_ok;
  logic                accept;
  logic [ADDR_W:0]     words_next;

  always_comb begin
    start_ok   = (num_words != '0) && (num_words <= MAX_WORDS);
    accept     = byte_valid && byte_ready;
    words_next = words_written + ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lane          <= '0;
      byte_buf      <= '0;
      num_words_q   <= '0;
      byte_ready    <= 1'b0;
      imem_we       <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      cpu_hold      <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      words_written <= '0;
      checksum      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (start_ok) begin
              state         <= LOAD;
              num_words_q   <= num_words;
              load_done     <= 1'b0;
              load_error    <= 1'b0;
              words_written <= '0;
              checksum      <= '0;
              lane          <= '0;
              byte_buf      <= '0;
              cpu_hold      <= 1'b1;
              byte_ready    <= 1'b1;
            end else begin
              state      <= IDLE;
              load_error <= 1'b1;
              load_done  <= 1'b0;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            if (lane == LAST_LANE) begin
              // words_written is also the index of the word being written,
              // so it doubles as the write address.
              imem_we    <= 1'b1;
              imem_waddr <= words_written[ADDR_W-1:0];
              imem_wdata <= {byte_buf, byte_data};
              byte_ready <= 1'b0;
              lane       <= '0;
              state      <= WRITE;
            end else begin
              byte_buf <= {byte_buf[DATA_W-17:0], byte_data};
              lane     <= lane + 2'd1;
            end
          end
        end

        WRITE: begin
          imem_we       <= 1'b0;
          checksum      <= checksum ^ imem_wdata;
          words_written <= words_next;
          if (words_next == num_words_q) begin
            state     <= DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end else begin
            state      <= LOAD;
            byte_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized and directed byte streams checked against a word-level reference model.
// Latency: monitors that each write lands exactly one cycle after the fourth byte of a word is accepted.
// Backpressure: drives byte_valid with random gaps and holds each byte until byte_ready takes it.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_written;
  logic [DATA_W-1:0] checksum;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_words     (num_words),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_error    (load_error),
    .words_written (words_written),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Everything the memory saw, in order.
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // Program bytes for the next load.
  logic [7:0] prog[$];

  int acc_cnt = 0;
  bit prev_l3 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: records writes and checks write timing / byte_ready behaviour.
  always @(negedge clk) begin
    if (prev_l3 || imem_we)
      check("we_one_cycle_after_lane3", 32'(imem_we), 32'(prev_l3));
    if (cpu_hold)
      check("rdy_drops_only_in_write", 32'(byte_ready), 32'(!imem_we));
    if (imem_we) begin
      wr_addr_q.push_back(imem_waddr);
      wr_data_q.push_back(imem_wdata);
    end
    if (!reset || (start && !cpu_hold)) begin
      acc_cnt = 0;
      prev_l3 = 1'b0;
    end else if (byte_valid && byte_ready) begin
      acc_cnt++;
      prev_l3 = (acc_cnt % 4 == 0);
    end else begin
      prev_l3 = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"},    32'(byte_ready), 0);
    check({tag, "_imem_we"},       32'(imem_we), 0);
    check({tag, "_imem_waddr"},    32'(imem_waddr), 0);
    check({tag, "_imem_wdata"},    imem_wdata, 0);
    check({tag, "_cpu_hold"},      32'(cpu_hold), 0);
    check({tag, "_load_done"},     32'(load_done), 0);
    check({tag, "_load_error"},    32'(load_error), 0);
    check({tag, "_words_written"}, 32'(words_written), 0);
    check({tag, "_checksum"},      checksum, 0);
  endtask

  task automatic pulse_start(input int n);
    num_words = (ADDR_W+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit spurious);
    int t;
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) begin
      byte_data = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    if (spurious) begin
      start     = 1'b1;
      num_words = (ADDR_W+1)'(1);
    end
    t = 0;
    forever begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ok) break;
      t++;
      if (t > 50) begin
        check("byte_accept_timeout", 0, 1);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  // Full load of n words from prog, checked against the word-level model.
  task automatic run_load(input int n, input int gap_lo, input int gap_hi, input bit spur);
    int base;
    int t;
    logic [31:0] w;
    logic [31:0] exp_ck;
    base   = wr_data_q.size();
    exp_ck = '0;
    pulse_start(n);
    check("start_cpu_hold",   32'(cpu_hold), 1);
    check("start_byte_ready", 32'(byte_ready), 1);
    check("start_done_clr",   32'(load_done), 0);
    check("start_err_clr",    32'(load_error), 0);
    check("start_ww_clr",     32'(words_written), 0);
    for (int i = 0; i < prog.size(); i++)
      send_byte(prog[i], int'($urandom_range(gap_hi, gap_lo)), spur && (i == 2));
    t = 0;
    while (!load_done && t < 20) begin
      tick();
      t++;
    end
    check("load_done_seen", 32'(load_done), 1);
    check("wr_count", 32'(wr_data_q.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      w = {prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3]};
      exp_ck ^= w;
      if (base + k < wr_data_q.size()) begin
        check("wr_addr", 32'(wr_addr_q[base+k]), 32'(k));
        check("wr_data", wr_data_q[base+k], w);
      end else begin
        check("wr_missing", 0, 1);
      end
    end
    check("done_checksum",      checksum, exp_ck);
    check("done_words_written", 32'(words_written), 32'(n));
    check("done_cpu_hold",      32'(cpu_hold), 0);
    check("done_byte_ready",    32'(byte_ready), 0);
    check("done_load_error",    32'(load_error), 0);
  endtask

  task automatic random_prog(input int n);
    prog.delete();
    for (int i = 0; i < 4*n; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    int n;

    // Reset held from time zero.
    repeat (3) tick();
    check_all_zero("in_reset");
    reset = 1'b1;
    tick();
    check_all_zero("after_reset");

    // Directed two-word load, back to back.
    prog = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
    run_load(2, 0, 0, 1'b0);
    check("dir_checksum", checksum, 32'h00010017);

    // Same program with a 3-cycle gap before every byte.
    run_load(2, 3, 3, 1'b0);
    check("gap_checksum", checksum, 32'h00010017);

    // Illegal word counts.
    base = wr_data_q.size();
    pulse_start(0);
    check("err0_load_error", 32'(load_error), 1);
    check("err0_load_done",  32'(load_done), 0);
    check("err0_cpu_hold",   32'(cpu_hold), 0);
    check("err0_byte_ready", 32'(byte_ready), 0);
    pulse_start(DEPTH + 1);
    check("err65_load_error", 32'(load_error), 1);
    check("err65_cpu_hold",   32'(cpu_hold), 0);
    repeat (4) tick();
    check("err_no_writes", 32'(wr_data_q.size() - base), 0);
    random_prog(1);
    run_load(1, 0, 1, 1'b0);

    // Full memory, word k = k.
    prog.delete();
    for (int k = 0; k < DEPTH; k++) begin
      prog.push_back(8'h00);
      prog.push_back(8'h00);
      prog.push_back(8'h00);
      prog.push_back(8'(k));
    end
    run_load(DEPTH, 0, 0, 1'b0);
    check("full_last_addr", 32'(wr_addr_q[$]), 32'(DEPTH - 1));
    check("full_last_data", wr_data_q[$], 32'h0000003F);
    check("full_checksum",  checksum, 32'h00000000);

    // Start pulsed in the middle of a load must be ignored.
    random_prog(3);
    run_load(3, 0, 2, 1'b1);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(8, 1));
      random_prog(n);
      run_load(n, 0, 2, r[0]);
    end

    // Reset after six bytes of a two-word load.
    random_prog(2);
    base = wr_data_q.size();
    pulse_start(2);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0, 1'b0);
    reset = 1'b0;
    #1;
    check_all_zero("midload_reset");
    check("midload_wr_count", 32'(wr_data_q.size() - base), 1);
    if (wr_data_q.size() > base) begin
      check("midload_wr_addr", 32'(wr_addr_q[base]), 0);
      check("midload_wr_data", wr_data_q[base], {prog[0], prog[1], prog[2], prog[3]});
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_byte_ready", 32'(byte_ready), 0);
    check("post_reset_cpu_hold",   32'(cpu_hold), 0);
    random_prog(1);
    run_load(1, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the word-addressed instruction memory. It accepts a program as a stream of bytes over a valid/ready handshake and packs each four bytes big-endian into a 32-bit instruction. It then writes each instruction into the memory's write port at consecutive word addresses. While loading it holds the datapath stalled, and it reports completion, word count and an XOR checksum of the loaded image.

Parameters:
DEPTH, 64, number of 32-bit instruction words in the memory
ADDR_W, 6, word-address width (log2 DEPTH); equals byte read address [7:2]
DATA_W, 32, instruction width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE
num_words  input  ADDR_W+1  number of words to load; legal range 1..DEPTH; sampled with start
byte_valid  input  1  byte_data is valid
byte_data  input  8  program byte, most-significant byte of each word first
byte_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
imem_waddr  output  ADDR_W  word address for the write
imem_wdata  output  DATA_W  assembled instruction
cpu_hold  output  1  stalls the PC/datapath while a load is in progress
load_done  output  1  level: last load completed successfully
load_error  output  1  level: last start carried an illegal num_words
words_written  output  ADDR_W+1  count of words written in the current or last load
checksum  output  DATA_W  XOR of all words written in the current or last load

Behaviour:
- All outputs are registered. While reset=0, every output is 0 and the FSM is in IDLE. Memory contents are not touched by reset.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE / DONE:
  - byte_ready=0, cpu_hold=0.
  - start with num_words in 1..DEPTH: go to LOAD next cycle. Clear load_done, load_error, words_written, checksum, byte lane and word address. Set cpu_hold=1.
  - start with num_words=0 or >DEPTH: set load_error=1, clear load_done, stay in (or return to) IDLE. cpu_hold stays 0.
- LOAD:
  - byte_ready=1.
  - A byte is accepted only when byte_valid && byte_ready.
  - Lane counter 0..3: lane 0 goes to [31:24], lane 1 to [23:16], lane 2 to [15:8], lane 3 to [7:0].
  - byte_valid low holds state with no timeout; gaps are allowed.
  - Accepting lane 3 moves to WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0.
  - imem_we=1, imem_waddr=current word index, imem_wdata=assembled word.
  - Latency: lane-3 byte accepted at edge N means imem_we is high in the cycle after edge N and deasserts at edge N+1.
  - At the end of WRITE: checksum ^= word, words_written += 1, word index += 1.
  - If the incremented words_written == num_words: go to DONE, load_done=1, cpu_hold=0. Otherwise return to LOAD.
- imem_we is 0 in every state except WRITE. imem_waddr and imem_wdata hold their last values when imem_we=0.
- Word index never wraps: it is bounded by num_words ≤ DEPTH, so the last possible address is DEPTH-1.
- start is ignored in LOAD and WRITE.
- Bytes offered when byte_ready=0 are not consumed; the source must hold them.
- Reset asserted mid-load: immediate abort. All outputs go to 0, including cpu_hold, and the FSM returns to IDLE. Words already written remain in memory. A partially assembled word is discarded.
- A load of fewer than num_words×4 bytes never completes; only reset or external control leaves LOAD.

Test Plan:
- Reset: assert reset=0 mid-operation -> all outputs 0, FSM IDLE; release -> byte_ready=0, cpu_hold=0.
- start, num_words=2; bytes 20 08 00 20 20 09 00 37 back-to-back -> imem_we pulses at waddr 0 with 0x20080020, then waddr 1 with 0x20090037, each one cycle after its 4th byte. Then checksum=0x00010017, words_written=2, load_done=1, cpu_hold=0.
- Same load with byte_valid low for 3 cycles between every byte -> identical writes and checksum; byte_ready drops only in WRITE cycles; no byte is lost or duplicated.
- start with num_words=0, then with 65 -> load_error=1, no imem_we, cpu_hold=0. A following legal start clears load_error.
- num_words=64 with word k = k -> 64 writes, last at waddr 63 with data 0x0000003F, checksum=0x00000000, words_written=64.
- start pulsed again during LOAD -> ignored. reset=0 after 6 bytes of a 2-word load -> exactly one write (waddr 0) occurred and all outputs return to 0.
